clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter DIVIDE, default 2, integer CLKIN_IN-to-CLKDV_OUT division ratio, legal range 2..16.
REQ-002 Parameter LOCK_CYCLES, default 16, CLKIN_IN rising edges from internal reset release to lock, legal range 1..1023.
REQ-003 CLKIN_IN  input  1  sole clock; all sequential logic is clocked on it.
REQ-004 RST_N_IN  input  1  reset; asynchronous, active-low.
REQ-005 CLKDV_OUT  output  1  divided clock, period DIVIDE x CLKIN_IN period.
REQ-006 CLKIN_IBUFG_OUT  output  1  buffered copy of CLKIN_IN.
REQ-007 CLK0_OUT  output  1  zero-phase copy of CLKIN_IN.
REQ-008 LOCKED_OUT  output  1  high when CLKDV_OUT is valid.

Function
REQ-009 CLKIN_IBUFG_OUT and CLK0_OUT SHALL be combinational copies of CLKIN_IN, independent of reset and lock.
REQ-010 An internal counter SHALL count 0..DIVIDE-1 on CLKIN_IN rising edges while locked, then wrap to 0.
REQ-011 Even DIVIDE: CLKDV_OUT SHALL be high for DIVIDE/2 input periods, then low for DIVIDE/2, with edges aligned to CLKIN_IN rising edges.
REQ-012 Odd DIVIDE: CLKDV_OUT SHALL have a 50% duty cycle.
REQ-013 Odd DIVIDE: CLKDV_OUT SHALL rise on a CLKIN_IN rising edge and fall on the CLKIN_IN falling edge in the middle of input period (DIVIDE+1)/2, via a falling-edge register.
REQ-014 Let E1 be the first CLKIN_IN rising edge with RST_N_IN high; the internal reset SHALL release at E2.
REQ-015 LOCKED_OUT SHALL rise at edge E(2+LOCK_CYCLES) and stay high until reset.
REQ-016 CLKDV_OUT SHALL remain low until LOCKED_OUT is high, then first rise at the same edge LOCKED_OUT rises, with counter value 0 at that edge.
REQ-017 CLKDV_OUT SHALL be glitch-free: no pulse shorter than one CLKIN_IN half-period.
REQ-018 Illegal DIVIDE or LOCK_CYCLES SHALL cause an elaboration-time error.

Reset
REQ-019 RST_N_IN low SHALL immediately force CLKDV_OUT=0, LOCKED_OUT=0, divider counter=0, lock counter=0, and the synchronizer to the asserted state.
REQ-020 Reset asserted mid-period SHALL truncate the current CLKDV_OUT high phase, and the full lock sequence of REQ-014..016 SHALL repeat after release.
REQ-021 Reset deassertion SHALL pass through a 2-flop synchronizer clocked by CLKIN_IN.

Configuration
REQ-022 Macro CLOCK_DIVIDER_LOCK_EN defined: lock counter present, and the behaviour of REQ-015 applies.
REQ-023 Macro CLOCK_DIVIDER_LOCK_EN undefined: no lock counter; LOCKED_OUT and the first CLKDV_OUT rise SHALL occur at E3; LOCK_CYCLES is ignored.

Structure
REQ-024 Package clock_divider_pkg SHALL hold: DIVIDE_MIN=2, DIVIDE_MAX=16, LOCK_CYCLES_MAX=1023, default values, and a counter-width function (clog2-based).
REQ-025 The reset synchronizer SHALL be sub-module clock_divider_rst_sync (ports CLK, RST_N_IN, RST_N_SYNC_OUT); everything else SHALL be inline.

Verification
REQ-026 Scenario 1 (CLKIN_IN 20 ns period, DIVIDE=2, lock enabled, LOCK_CYCLES=16, reset released before E1): LOCKED_OUT rises at E18; CLKDV_OUT period 40 ns, high 20 ns.
REQ-027 Scenario 2 (DIVIDE=3, lock disabled): LOCKED_OUT and the first CLKDV_OUT rise occur at E3; CLKDV_OUT period 60 ns, high exactly 30 ns, low 30 ns.
REQ-028 Scenario 3 (DIVIDE=16): CLKDV_OUT period 320 ns, high 160 ns; the counter wraps 15 to 0 on the rising CLKDV_OUT edge.
REQ-029 Scenario 4 (RST_N_IN pulled low 5 ns after a CLKDV_OUT rise): CLKDV_OUT and LOCKED_OUT are 0 within the same timestep; after release, relock occurs at E(2+LOCK_CYCLES).
REQ-030 Scenario 5 (any configuration, including during reset): CLK0_OUT and CLKIN_IBUFG_OUT equal CLKIN_IN at every sample.
REQ-031 Scenario 6 (DIVIDE=1, then DIVIDE=17): elaboration fails.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared limits, defaults and sizing helper for the clock_divider block.
package clock_divider_pkg;

  localparam int DIVIDE_MIN          = 2;
  localparam int DIVIDE_MAX          = 16;
  localparam int DIVIDE_DEFAULT      = 2;
  localparam int LOCK_CYCLES_MIN     = 1;
  localparam int LOCK_CYCLES_MAX     = 1023;
  localparam int LOCK_CYCLES_DEFAULT = 16;

  // Bits needed for a counter holding 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second CLK edge.
module clock_divider_rst_sync (
  input  logic CLK,
  input  logic RST_N_IN,
  output logic RST_N_SYNC_OUT
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  // NOTE: flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign RST_N_SYNC_OUT = sync_q;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider with reset synchronizer and lock indication.
// Define CLOCK_DIVIDER_LOCK_EN to hold LOCKED_OUT off for LOCK_CYCLES edges after reset release.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int DIVIDE      = DIVIDE_DEFAULT,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
  input  logic CLKIN_IN,
  input  logic RST_N_IN,
  output logic CLKDV_OUT,
  output logic CLKIN_IBUFG_OUT,
  output logic CLK0_OUT,
  output logic LOCKED_OUT
);

  localparam int                 DIV_W     = cnt_width(DIVIDE);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIVIDE - 1);
  // Last count of the rising-edge high phase; odd ratios trim half a period off it.
  localparam logic [DIV_W-1:0]   HIGH_LAST = DIV_W'((DIVIDE - 1) / 2);

  if (DIVIDE < DIVIDE_MIN || DIVIDE > DIVIDE_MAX) begin : g_bad_divide
    $error("clock_divider: DIVIDE=%0d outside %0d..%0d", DIVIDE, DIVIDE_MIN, DIVIDE_MAX);
  end
  if (LOCK_CYCLES < LOCK_CYCLES_MIN || LOCK_CYCLES > LOCK_CYCLES_MAX) begin : g_bad_lock
    $error("clock_divider: LOCK_CYCLES=%0d outside %0d..%0d", LOCK_CYCLES, LOCK_CYCLES_MIN,
           LOCK_CYCLES_MAX);
  end

  assign CLKIN_IBUFG_OUT = CLKIN_IN;
  assign CLK0_OUT        = CLKIN_IN;

  logic rst_sync_n;

  clock_divider_rst_sync u_rst_sync (
    .CLK            (CLKIN_IN),
    .RST_N_IN       (RST_N_IN),
    .RST_N_SYNC_OUT (rst_sync_n)
  );

  logic lock_done;

`ifdef CLOCK_DIVIDER_LOCK_EN
  localparam int               LOCK_W    = cnt_width(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!LOCKED_OUT && lock_cnt_q != LOCK_LAST) lock_cnt_d = lock_cnt_q + 1'b1;
  end

  always_ff @(posedge CLKIN_IN or negedge rst_sync_n) begin
    if (!rst_sync_n) lock_cnt_q <= '0;
    else             lock_cnt_q <= lock_cnt_d;
  end

  assign lock_done = (lock_cnt_q == LOCK_LAST);
`else
  assign lock_done = 1'b1;
`endif

  logic             locked_q, locked_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pos_q, pos_d;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    locked_d  = locked_q | lock_done;
    div_cnt_d = '0;
    if (locked_q) div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pos_d     = locked_d && (div_cnt_d <= HIGH_LAST);
  end

  always_ff @(posedge CLKIN_IN or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      locked_q  <= 1'b0;
      div_cnt_q <= '0;
      pos_q     <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      div_cnt_q <= div_cnt_d;
      pos_q     <= pos_d;
    end
  end

  assign LOCKED_OUT = locked_q;

  if (DIVIDE % 2 == 1) begin : g_odd
    // Falling-edge flop cuts the last high period in half; pos_q and kill_q never toggle together.
    logic kill_q, kill_d;

    always_comb begin
      kill_d = pos_q && (div_cnt_q == HIGH_LAST);
    end

    always_ff @(negedge CLKIN_IN or negedge rst_sync_n) begin
      if (!rst_sync_n) kill_q <= 1'b0;
      else             kill_q <= kill_d;
    end

    assign CLKDV_OUT = pos_q & ~kill_q;
  end else begin : g_even
    assign CLKDV_OUT = pos_q;
  end

endmodule

// File: tb/tb_clock_divider.sv
// Randomized self-checking bench: four divider configurations against a half-period arithmetic model.
module tb_clock_divider;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] clkdv, locked, ibufg, clk0;

  int n_checks = 0;
  int n_pass   = 0;
  int e_cnt    = 0;  // index of the last rising edge seen with reset high (E1 = 1)

  function automatic int div_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      2:       return 16;
      default: return 5;
    endcase
  endfunction

  function automatic int lock_of(input int i);
    case (i)
      0:       return 16;
      1:       return 1;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int lock_edge(input int i);
`ifdef CLOCK_DIVIDER_LOCK_EN
    return 2 + lock_of(i);
`else
    return 3;
`endif
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    clock_divider #(
      .DIVIDE      (div_of(g)),
      .LOCK_CYCLES (lock_of(g))
    ) u_dut (
      .CLKIN_IN        (clk),
      .RST_N_IN        (rst_n),
      .CLKDV_OUT       (clkdv[g]),
      .CLKIN_IBUFG_OUT (ibufg[g]),
      .CLK0_OUT        (clk0[g]),
      .LOCKED_OUT      (locked[g])
    );
  end

  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_cnt = 0;
    else        e_cnt = e_cnt + 1;
  end

  function automatic logic exp_locked(input int i);
    return e_cnt >= lock_edge(i);
  endfunction

  // Divided clock is high for the first DIVIDE half-periods of each 2*DIVIDE half-period cycle.
  function automatic logic exp_clkdv(input int i, input int phase);
    int m;
    if (e_cnt < lock_edge(i)) return 1'b0;
    m = (e_cnt - lock_edge(i)) % div_of(i);
    return (2 * m + phase) < div_of(i);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic sample(input int phase);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clk0[%0d]", i), clk0[i], clk);
      check($sformatf("ibufg[%0d]", i), ibufg[i], clk);
      check($sformatf("clkdv[%0d] e=%0d ph=%0d", i, e_cnt, phase), clkdv[i], exp_clkdv(i, phase));
      check($sformatf("locked[%0d] e=%0d", i, e_cnt), locked[i], exp_locked(i));
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #5; sample(0);
      @(negedge clk); #5; sample(1);
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s clkdv[%0d]", tag, i), clkdv[i], 1'b0);
      check($sformatf("%s locked[%0d]", tag, i), locked[i], 1'b0);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #($urandom_range(2, 8));
    rst_n = 1'b1;
  endtask

  // Assert reset 5 ns after a rise of the DIVIDE=2 output.
  task automatic reset_after_rise();
    logic prev;
    bit   found;
    prev  = clkdv[0];
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (clkdv[0] && !prev) found = 1'b1;
      prev = clkdv[0];
    end
    if (!found) begin
      check("rise_timeout", 1'b0, 1'b1);
    end else begin
      #4;
      rst_n = 1'b0;
      #1;
      check_cleared("rise_rst");
    end
    rst_n = 1'b0;
  endtask

  task automatic reset_random();
    int off;
    @(posedge clk);
    off = $urandom_range(0, 1) ? $urandom_range(2, 8) : $urandom_range(12, 18);
    #(off);
    rst_n = 1'b0;
    #1;
    check_cleared("rand_rst");
  endtask

  initial begin
    rst_n = 1'b0;
    run_cycles(3);
    release_reset();
    run_cycles(80);

    reset_after_rise();
    run_cycles($urandom_range(1, 4));
    release_reset();
    run_cycles(80);

    for (int it = 0; it < 3; it++) begin
      run_cycles($urandom_range(0, 30));
      reset_random();
      run_cycles($urandom_range(1, 5));
      release_reset();
      run_cycles(60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
